// File: rtl/cla_seq_pkg.sv
// Shared definitions for the multi-word carry-lookahead sequencer.
// Holds the FSM state type, default slice geometry (reused by the
// interface and the bench) and the signed-overflow helper.
package cla_seq_pkg;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_NUM_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Two's-complement overflow of the top word: carry into the MSB
  // (a ^ b ^ s at the MSB) differs from the carry out of the MSB.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic c_out);
    return c_out ^ (a_msb ^ b_msb ^ s_msb);
  endfunction

endpackage

// File: rtl/cla_multiword_sequencer_if.sv
// Bus bundle for cla_multiword_sequencer.
// Groups the operand request channel (in_valid/in_ready/op_*), the adder
// slice connection (add_*) and the result channel (out_valid/out_ready/
// sum/cout/ovf).
//   slave  : the sequencer side
//   master : the surrounding datapath plus the combinational adder slice
interface cla_multiword_sequencer_if #(
  parameter int WORD_W    = cla_seq_pkg::DEF_WORD_W,
  parameter int NUM_WORDS = cla_seq_pkg::DEF_NUM_WORDS
);
  localparam int TOT_W = WORD_W * NUM_WORDS;

  logic              in_valid;
  logic              in_ready;
  logic [TOT_W-1:0]  op_a;
  logic [TOT_W-1:0]  op_b;
  logic              op_cin;
  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b;
  logic              add_cin;
  logic [WORD_W-1:0] add_s;
  logic              add_cout;
  logic              out_valid;
  logic              out_ready;
  logic [TOT_W-1:0]  sum;
  logic              cout;
  logic              ovf;

  modport slave (
    input  in_valid, op_a, op_b, op_cin, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, op_a, op_b, op_cin, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cla_multiword_sequencer.sv
// Drives an external WORD_W-bit carry-lookahead adder slice over NUM_WORDS
// cycles to add two TOT_W-bit operands, least-significant word first, with
// the inter-word carry chained through a register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all state immediately
//   bus   : cla_multiword_sequencer_if.slave (request, adder, result)
module cla_multiword_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cla_multiword_sequencer_if.slave  bus
);

  localparam int TOT_W = WORD_W * NUM_WORDS;
  localparam int KW    = $clog2(NUM_WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);

  seq_state_t        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic              carry_q, carry_d;
  logic [TOT_W-1:0]  a_q, a_d;
  logic [TOT_W-1:0]  b_q, b_d;
  logic              cin_q, cin_d;
  logic [TOT_W-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [WORD_W-1:0] a_word_s;
  logic [WORD_W-1:0] b_word_s;
  logic              cin_s;

  // Adder slice drive: current word and chained carry in RUN, zero otherwise.
  always_comb begin
    a_word_s = '0;
    b_word_s = '0;
    cin_s    = 1'b0;
    if (state_q == RUN) begin
      a_word_s = a_q[int'(k_q)*WORD_W +: WORD_W];
      b_word_s = b_q[int'(k_q)*WORD_W +: WORD_W];
      cin_s    = (k_q == '0) ? cin_q : carry_q;
    end else begin
      a_word_s = '0;
      b_word_s = '0;
      cin_s    = 1'b0;
    end
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          cin_d   = bus.op_cin;
          sum_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[int'(k_q)*WORD_W +: WORD_W] = bus.add_s;
        carry_d = bus.add_cout;
        if (k_q == K_LAST) begin
          // Hold k on the last word so the counter never wraps inside RUN.
          cout_d  = bus.add_cout;
          ovf_d   = signed_ovf(a_word_s[WORD_W-1], b_word_s[WORD_W-1],
                               bus.add_s[WORD_W-1], bus.add_cout);
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.add_a     = a_word_s;
  assign bus.add_b     = b_word_s;
  assign bus.add_cin   = cin_s;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Directed self-checking bench for cla_multiword_sequencer with a
// behavioural 32-bit adder slice attached to the add_* signals.
module tb_cla_multiword_sequencer;
  import cla_seq_pkg::*;

  localparam int W = DEF_WORD_W;
  localparam int N = DEF_NUM_WORDS;
  localparam int T = W * N;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_multiword_sequencer_if #(.WORD_W(W), .NUM_WORDS(N)) bus ();

  cla_multiword_sequencer #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational adder slice sitting next to the sequencer.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                   + {{W{1'b0}}, bus.add_cin};

  task automatic chk(input string tag, input logic [T-1:0] obs, input logic [T-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then wait (bounded) for out_valid; records add_cin
  // seen on each word and the number of edges from accept to out_valid.
  task automatic do_tx(input logic [T-1:0] a, input logic [T-1:0] b, input logic c,
                       output logic [3:0] cins, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    bus.op_a = a;
    bus.op_b = b;
    bus.op_cin = c;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    cins = 4'b0000;
    while (!bus.out_valid && lat < 20) begin
      if (lat < 4) cins[lat] = bus.add_cin;
      tick();
      lat++;
    end
  endtask

  task automatic release_result;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   cins;
    int           lat;
    logic [T-1:0] ones;
    logic [T-1:0] ta [3];
    logic [T-1:0] tb [3];
    logic [T:0]   full;
    logic         seen;
    int           t_prev;
    int           w;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.op_cin = 1'b0;
    ones = '1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_add_cin", bus.add_cin, 0);
    #12 rst_n = 1'b1;
    tick();

    // Simple add
    do_tx(128'd1, 128'd1, 1'b0, cins, lat);
    chk("simple_lat", lat, 4);
    chk("simple_sum", bus.sum, 128'd2);
    chk("simple_cout", bus.cout, 0);
    chk("simple_ovf", bus.ovf, 0);
    chk("simple_cins", cins, 4'b0000);
    release_result();
    chk("simple_drop", bus.out_valid, 0);
    chk("simple_ready", bus.in_ready, 1);

    // Full carry ripple
    do_tx(ones, 128'd1, 1'b0, cins, lat);
    chk("ripple_sum", bus.sum, 0);
    chk("ripple_cout", bus.cout, 1);
    chk("ripple_ovf", bus.ovf, 0);
    chk("ripple_cins", cins, 4'b1110);
    release_result();

    // Signed overflow, positive
    do_tx(128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, cins, lat);
    chk("ovfp_sum", bus.sum, 128'h80000000_00000000_00000000_00000000);
    chk("ovfp_cout", bus.cout, 0);
    chk("ovfp_ovf", bus.ovf, 1);
    release_result();

    // Signed overflow, negative
    do_tx(128'h80000000_00000000_00000000_00000000,
          128'h80000000_00000000_00000000_00000000, 1'b0, cins, lat);
    chk("ovfn_sum", bus.sum, 0);
    chk("ovfn_cout", bus.cout, 1);
    chk("ovfn_ovf", bus.ovf, 1);
    release_result();

    // Backpressure
    do_tx(128'd7, 128'd8, 1'b0, cins, lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.op_a = 128'd5;
      bus.op_b = 128'd0;
      tick();
      chk("bp_sum", bus.sum, 128'd15);
      chk("bp_cout", bus.cout, 0);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("bp_drop", bus.out_valid, 0);
    chk("bp_sum_held", bus.sum, 128'd15);
    tick();
    chk("bp_not_accepted", bus.in_ready, 1);

    // Reset mid-run at k==2
    bus.op_a = 128'd100;
    bus.op_b = 128'd200;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_add_a", bus.add_a, 0);
    chk("mrst_add_b", bus.add_b, 0);
    chk("mrst_add_cin", bus.add_cin, 0);
    chk("mrst_sum", bus.sum, 0);
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_ready", bus.in_ready, 1);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mrst_no_valid", seen, 0);
    chk("mrst_ready_after", bus.in_ready, 1);
    do_tx(128'd3, 128'd4, 1'b0, cins, lat);
    chk("mrst_sum7", bus.sum, 128'd7);
    release_result();

    // Back-to-back stream with cin=1
    ta[0] = {4{32'h89ABCDEF}};
    tb[0] = {4{32'h76543210}};
    ta[1] = 128'h7FFFFFFF_00000000_FFFFFFFF_12345678;
    tb[1] = 128'h00000001_00000000_00000001_87654321;
    ta[2] = 128'hDEADBEEF_CAFEF00D_01234567_FFFFFFFE;
    tb[2] = 128'h9ABCDEF0_11111111_FEDCBA98_00000001;
    bus.out_ready = 1'b1;
    bus.op_cin = 1'b1;
    t_prev = 0;
    for (int t = 0; t < 3; t++) begin
      w = 0;
      while (!bus.in_ready && w < 20) begin
        tick();
        w++;
      end
      bus.op_a = ta[t];
      bus.op_b = tb[t];
      bus.in_valid = 1'b1;
      tick();
      if (t == 2) bus.in_valid = 1'b1;
      w = 0;
      while (!bus.out_valid && w < 20) begin
        tick();
        w++;
      end
      if (t == 2) bus.in_valid = 1'b0;
      full = {1'b0, ta[t]} + {1'b0, tb[t]} + {{T{1'b0}}, 1'b1};
      chk("b2b_sum", bus.sum, full[T-1:0]);
      chk("b2b_cout", bus.cout, full[T]);
      chk("b2b_ovf", bus.ovf, (ta[t][T-1] == tb[t][T-1]) && (full[T-1] != ta[t][T-1]));
      if (t > 0) chk("b2b_period", cyc - t_prev, 6);
      t_prev = cyc;
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    tick();
    chk("b2b_idle", bus.in_ready, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
